spi_sort_engine: RTL and testbench
==================================

Name: spi_sort_engine

Overview:
SPI-slave front end with an integrated parametrised insertion-sort buffer. It is the successor to the fixed 8-bit single-sorter wrapper: DATA_WIDTH is any value from 1 to 32 and is no longer tied to one SPI frame. Multi-byte payloads use a command byte, and the sorted contents plus occupancy are read back over the same link. It sits between the board-level SPI pins and the host microcontroller test harness.

Parameters:
- DATA_WIDTH, 8, width of each stored value (1..32); DATA_BYTES = ceil(DATA_WIDTH/8) bytes per value on the wire.
- SIZE, 3, number of sort entries (1..64).
- CNT_W, $clog2(SIZE+1), width of the occupancy count (derived; not overridden).

Ports:
- clk  input  1  system clock; must be at least 4x sck.
- reset  input  1  synchronous, active-high reset.
- sck  input  1  SPI clock, mode 0, asynchronous to clk.
- mosi  input  1  SPI data in, MSB first.
- cs  input  1  SPI chip select, active low.
- miso  output  1  SPI data out, MSB first.
- count  output  CNT_W  number of valid entries.
- full  output  1  high when count == SIZE.

Behaviour:
- Reset (sync, active-high): all entries 0, count 0, full 0, miso 0, frame FSM to IDLE, shift registers cleared.
  - A frame in progress at reset is dropped. The FSM stays IDLE until cs is seen high and then low again.
- Input sync: sck, mosi and cs each pass through 2 flops into clk.
  - Rising- and falling-sck events are detected from the synced sck.
  - mosi is sampled on the rising event; miso updates on the falling event.
- Frame FSM states: IDLE, CMD, PAYLOAD, EXEC, TX, DRAIN.
  - IDLE -> CMD on synced cs falling.
  - CMD: shift 8 bits. On the 8th bit, decode:
    - 0x01 INSERT -> PAYLOAD.
    - 0x02 READ -> snapshot entries and count, then TX.
    - 0x03 CLEAR -> EXEC.
    - 0x04 COUNT -> TX with a 1-byte count.
    - Any other code -> DRAIN.
  - PAYLOAD: shift 8*DATA_BYTES bits. Value = low DATA_WIDTH bits; excess upper bits are ignored. Last bit -> EXEC.
  - EXEC: one clk cycle; performs the insert or clear, then -> DRAIN.
  - TX: READ sends SIZE entries, index 0 first, each zero-padded to DATA_BYTES bytes, MSB first. COUNT sends count zero-extended to 8 bits. Extra clocks after the data shift out 0.
  - DRAIN: ignore sck, miso 0.
  - Any state -> IDLE on synced cs rising. An incomplete PAYLOAD is discarded with no insert.
- miso is 0 during CMD and PAYLOAD. The first TX bit is presented on the falling event after the 8th command bit.
- Insert, single cycle:
  - Ascending order; index 0 holds the smallest value. Comparison is unsigned.
  - Each valid entry i with entry[i] > v shifts to i+1. v is written at the lowest such index, or at index count if none.
  - Equal values: the new value goes after existing equal values (stable).
  - count increments if not full.
  - Full case: if v < entry[SIZE-1], the largest entry is discarded and count stays SIZE. Otherwise the insert is ignored.
- Clear: all entries 0, count 0, in the EXEC cycle.
- Invalid entries (index >= count) always read as 0.
- count and full update on the clk edge ending EXEC; latency from the last payload sck rise is at most 4 clk.
- READ uses the snapshot taken at command decode. Entries cannot change mid-TX, because inserts only occur in other frames.

Optional Feature:
- Macro SPI_SORT_DESCENDING_EN.
- Defined: index 0 holds the largest value.
  - Shift condition becomes entry[i] < v.
  - Full case: discard entry[SIZE-1] only if v > entry[SIZE-1].
  - Equal-value placement stays stable.
- Undefined: ascending behaviour as above. The ports are identical in both builds.

Test Plan:
- Reset, then READ with SIZE=3, DATA_WIDTH=8 -> miso bytes 00 00 00; count=0, full=0.
- INSERT 0x50, 0x10, 0x30, then READ -> bytes 10 30 50; count=3, full=1.
- Full buffer {10,30,50}: INSERT 0x20 -> READ gives 10 20 30. Then INSERT 0x60 -> contents unchanged, count stays 3.
- DATA_WIDTH=12: INSERT payload bytes F4 56 -> stored 0x456. READ returns 04 56 00 00 00 00; COUNT command returns 0x01.
- INSERT frame with cs raised after 4 payload bits -> no change, count 0. Next INSERT 0x07 succeeds, count 1.
- Command 0x7E then 16 sck -> miso stays 0, no state change. CLEAR -> count 0 and READ returns all zeros. Reset asserted mid-PAYLOAD -> frame ignored until cs toggles.

Source files
------------

// File: rtl/spi_sort_engine_if.sv
// SPI pin bundle for spi_sort_engine: the host side drives sck/mosi/cs, the engine drives miso.
interface spi_sort_engine_if;
    logic sck;
    logic mosi;
    logic cs;
    logic miso;

    modport master (output sck, output mosi, output cs, input miso);
    modport slave  (input sck, input mosi, input cs, output miso);
endinterface

// File: rtl/spi_sort_engine.sv
// SPI-slave command front end with a single-cycle insertion-sort buffer of SIZE entries.
// Build option: define SPI_SORT_DESCENDING_EN to keep the largest value at index 0.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for cs to fall
// S_CMD     | shifting in the 8-bit command byte
// S_PAYLOAD | shifting in 8*DATA_BYTES bits of insert value
// S_EXEC    | one clk: apply insert or clear
// S_TX      | shifting snapshot (READ) or count (COUNT) out on miso
// S_DRAIN   | ignore sck until cs rises
module spi_sort_engine #(
    parameter int DATA_WIDTH = 8,
    parameter int SIZE       = 3,
    parameter int CNT_W      = $clog2(SIZE + 1)
) (
    input  logic             clk,
    input  logic             reset,
    spi_sort_engine_if.slave spi,
    output logic [CNT_W-1:0] count,
    output logic             full
);

    localparam int DATA_BYTES = (DATA_WIDTH + 7) / 8;
    localparam int EW         = 8 * DATA_BYTES;
    localparam int TX_W       = SIZE * EW;
    localparam logic [5:0] CMD_LAST = 6'd7;
    localparam logic [5:0] PAY_LAST = 6'(EW - 1);

    localparam logic [7:0] CMD_INSERT = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_CLEAR  = 8'h03;
    localparam logic [7:0] CMD_COUNT  = 8'h04;

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_PAYLOAD, S_EXEC, S_TX, S_DRAIN
    } state_t;

    state_t state_q, state_d;

    logic [1:0] sck_sync, mosi_sync, cs_sync;
    logic       sck_prev, cs_prev;
    logic       sck_rise, sck_fall, cs_rise, cs_fall, mosi_s;

    logic [5:0]      bits_left;
    logic [EW-1:0]   shift_reg;
    logic [7:0]      cmd_byte;
    logic            op_clear;
    logic [TX_W-1:0] tx_reg;
    logic [TX_W-1:0] snap;
    logic            miso_q;

    logic [DATA_WIDTH-1:0] entry     [SIZE];
    logic [DATA_WIDTH-1:0] ins_entry [SIZE];
    logic [DATA_WIDTH-1:0] ins_val;
    logic [SIZE-1:0]       moves;

    logic shift_en, cmd_done, load_read, load_cnt, tx_shift, do_insert, do_clear;

    // Two-flop synchronisers plus one history flop for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            cs_sync   <= '0;
            sck_prev  <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], spi.sck};
            mosi_sync <= {mosi_sync[0], spi.mosi};
            cs_sync   <= {cs_sync[0], spi.cs};
            sck_prev  <= sck_sync[1];
            cs_prev   <= cs_sync[1];
        end
    end

    assign sck_rise = sck_sync[1] & ~sck_prev;
    assign sck_fall = ~sck_sync[1] & sck_prev;
    assign cs_rise  = cs_sync[1] & ~cs_prev;
    assign cs_fall  = ~cs_sync[1] & cs_prev;
    assign mosi_s   = mosi_sync[1];
    assign cmd_byte = {shift_reg[6:0], mosi_s};

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cs_rise) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    if (cs_fall) state_d = S_CMD;
                S_CMD: begin
                    if (sck_rise && bits_left == '0) begin
                        case (cmd_byte)
                            CMD_INSERT: state_d = S_PAYLOAD;
                            CMD_READ:   state_d = S_TX;
                            CMD_COUNT:  state_d = S_TX;
                            CMD_CLEAR:  state_d = S_EXEC;
                            default:    state_d = S_DRAIN;
                        endcase
                    end
                end
                S_PAYLOAD: if (sck_rise && bits_left == '0) state_d = S_EXEC;
                S_EXEC:    state_d = S_DRAIN;
                default:   state_d = state_q;
            endcase
        end
    end

    always_comb begin
        shift_en  = 1'b0;
        cmd_done  = 1'b0;
        load_read = 1'b0;
        load_cnt  = 1'b0;
        tx_shift  = 1'b0;
        if (!cs_rise) begin
            case (state_q)
                S_CMD: begin
                    shift_en  = sck_rise;
                    cmd_done  = sck_rise && bits_left == '0;
                    load_read = cmd_done && cmd_byte == CMD_READ;
                    load_cnt  = cmd_done && cmd_byte == CMD_COUNT;
                end
                S_PAYLOAD: shift_en = sck_rise;
                S_TX:      tx_shift = sck_fall;
                default:   ;
            endcase
        end
        do_insert = (state_q == S_EXEC) && !op_clear;
        do_clear  = (state_q == S_EXEC) && op_clear;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bits_left <= '0;
            shift_reg <= '0;
            op_clear  <= 1'b0;
            tx_reg    <= '0;
            miso_q    <= 1'b0;
        end else begin
            if (state_d == S_CMD && state_q != S_CMD)
                bits_left <= CMD_LAST;
            else if (state_d == S_PAYLOAD && state_q != S_PAYLOAD)
                bits_left <= PAY_LAST;
            else if (shift_en)
                bits_left <= bits_left - 6'd1;

            if (shift_en)
                shift_reg <= {shift_reg[EW-2:0], mosi_s};

            if (cmd_done)
                op_clear <= (cmd_byte == CMD_CLEAR);

            if (load_read)
                tx_reg <= snap;
            else if (load_cnt)
                tx_reg <= TX_W'(8'(count)) << (TX_W - 8);
            else if (tx_shift)
                tx_reg <= tx_reg << 1;

            if (state_q != S_TX)
                miso_q <= 1'b0;
            else if (tx_shift)
                miso_q <= tx_reg[TX_W-1];
        end
    end

    assign spi.miso = miso_q;

    // Entries above count are masked so the snapshot never leaks stale data.
    always_comb begin
        snap = '0;
        for (int i = 0; i < SIZE; i++) begin
            if (CNT_W'(i) < count)
                snap[TX_W-1-i*EW -: EW] = EW'(entry[i]);
        end
    end

    assign ins_val = shift_reg[DATA_WIDTH-1:0];

    // Entries that sort after the new value move up one slot; the value lands at the
    // lowest moved slot, or at index count when nothing moves. Strict compare keeps
    // equal values in arrival order; when full, the top entry simply falls off.
    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
`ifdef SPI_SORT_DESCENDING_EN
            moves[i] = (CNT_W'(i) < count) && (entry[i] < ins_val);
`else
            moves[i] = (CNT_W'(i) < count) && (entry[i] > ins_val);
`endif
        end
        ins_entry[0] = (moves[0] || count == '0) ? ins_val : entry[0];
        for (int i = 1; i < SIZE; i++) begin
            if (moves[i-1])
                ins_entry[i] = entry[i-1];
            else if (moves[i] || CNT_W'(i) == count)
                ins_entry[i] = ins_val;
            else
                ins_entry[i] = entry[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset || do_clear) begin
            for (int i = 0; i < SIZE; i++) entry[i] <= '0;
            count <= '0;
        end else if (do_insert) begin
            for (int i = 0; i < SIZE; i++) entry[i] <= ins_entry[i];
            if (!full) count <= count + CNT_W'(1);
        end
    end

    assign full = (count == CNT_W'(SIZE));

endmodule

// File: tb/tb_spi_sort_engine.sv
// Self-checking bench for spi_sort_engine: an 8-bit and a 12-bit instance share sck/mosi,
// each has its own cs; READ/COUNT replies are checked against a queue-based sort model.
module tb_spi_sort_engine;
    localparam int SIZE = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    spi_sort_engine_if if8();
    spi_sort_engine_if if12();

    logic [1:0] count8, count12;
    logic       full8, full12;

    spi_sort_engine #(.DATA_WIDTH(8), .SIZE(SIZE)) u_dut8 (
        .clk(clk), .reset(reset), .spi(if8), .count(count8), .full(full8)
    );
    spi_sort_engine #(.DATA_WIDTH(12), .SIZE(SIZE)) u_dut12 (
        .clk(clk), .reset(reset), .spi(if12), .count(count12), .full(full12)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int model8[$];
    int model12[$];
    logic [7:0] exp_q[$];

    task automatic half_period();
        repeat (8) @(negedge clk);
    endtask

    task automatic set_sck(input logic v);
        if8.sck  = v;
        if12.sck = v;
    endtask

    task automatic set_mosi(input logic v);
        if8.mosi  = v;
        if12.mosi = v;
    endtask

    task automatic set_cs(input int sel, input logic v);
        if (sel == 8) if8.cs = v;
        else          if12.cs = v;
    endtask

    function automatic logic miso_of(input int sel);
        return (sel == 8) ? if8.miso : if12.miso;
    endfunction

    // Send the top nbits of tx MSB first; rx holds what miso showed at each rising sck.
    task automatic spi_bits(input int sel, input logic [7:0] tx, input int nbits,
                            output logic [7:0] rx);
        rx = '0;
        for (int b = 7; b > 7 - nbits; b--) begin
            set_mosi(tx[b]);
            half_period();
            set_sck(1'b1);
            rx[b] = miso_of(sel);
            half_period();
            set_sck(1'b0);
        end
    endtask

    task automatic frame_begin(input int sel);
        set_cs(sel, 1'b0);
        half_period();
    endtask

    task automatic frame_end(input int sel);
        half_period();
        set_cs(sel, 1'b1);
        repeat (10) @(negedge clk);
    endtask

    task automatic model_insert(input int sel, input int v);
        int q[$];
        q = (sel == 8) ? model8 : model12;
        if (q.size() < SIZE) begin
            q.push_back(v);
        end else begin
`ifdef SPI_SORT_DESCENDING_EN
            if (v > q[SIZE-1]) q[SIZE-1] = v;
`else
            if (v < q[SIZE-1]) q[SIZE-1] = v;
`endif
        end
`ifdef SPI_SORT_DESCENDING_EN
        q.rsort();
`else
        q.sort();
`endif
        if (sel == 8) model8 = q;
        else          model12 = q;
    endtask

    task automatic spi_insert(input int sel, input logic [15:0] payload);
        logic [7:0] rx;
        frame_begin(sel);
        spi_bits(sel, 8'h01, 8, rx);
        if (sel == 12) spi_bits(sel, payload[15:8], 8, rx);
        spi_bits(sel, payload[7:0], 8, rx);
        frame_end(sel);
        model_insert(sel, (sel == 8) ? int'(payload[7:0]) : int'(payload[11:0]));
    endtask

    task automatic spi_clear(input int sel);
        logic [7:0] rx;
        frame_begin(sel);
        spi_bits(sel, 8'h03, 8, rx);
        frame_end(sel);
        if (sel == 8) model8.delete();
        else          model12.delete();
    endtask

    // Scoreboard: expected reply bytes (plus one trailing zero byte) are queued from the
    // model as the command goes out, then popped against each byte miso delivers.
    task automatic spi_read(input int sel, input string name);
        int q[$];
        int nb;
        int v;
        logic [7:0] rx, e;
        q  = (sel == 8) ? model8 : model12;
        nb = (sel == 8) ? 1 : 2;
        for (int i = 0; i < SIZE; i++) begin
            v = (i < q.size()) ? q[i] : 0;
            for (int b = nb - 1; b >= 0; b--) exp_q.push_back(8'(v >> (8 * b)));
        end
        exp_q.push_back(8'h00);
        frame_begin(sel);
        spi_bits(sel, 8'h02, 8, rx);
        n_checks++;
        if (rx !== 8'h00) begin
            n_fail++;
            $display("FAIL %s cmd_miso: got %02h want 00", name, rx);
        end
        for (int k = 0; k < SIZE * nb + 1; k++) begin
            spi_bits(sel, 8'h00, 8, rx);
            e = exp_q.pop_front();
            n_checks++;
            if (rx !== e) begin
                n_fail++;
                $display("FAIL %s byte%0d: got %02h want %02h", name, k, rx, e);
            end
        end
        frame_end(sel);
    endtask

    task automatic spi_count(input int sel, input string name);
        logic [7:0] rx, e;
        exp_q.push_back(8'((sel == 8) ? model8.size() : model12.size()));
        frame_begin(sel);
        spi_bits(sel, 8'h04, 8, rx);
        spi_bits(sel, 8'h00, 8, rx);
        frame_end(sel);
        e = exp_q.pop_front();
        n_checks++;
        if (rx !== e) begin
            n_fail++;
            $display("FAIL %s count_reply: got %02h want %02h", name, rx, e);
        end
    endtask

    task automatic test_reset();
        n_checks++;
        if (count8 !== 2'd0 || full8 !== 1'b0 || if8.miso !== 1'b0) begin
            n_fail++;
            $display("FAIL reset8: got count=%0d full=%0b miso=%0b want 0 0 0",
                     count8, full8, if8.miso);
        end
        n_checks++;
        if (count12 !== 2'd0 || full12 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset12: got count=%0d full=%0b want 0 0", count12, full12);
        end
        spi_read(8, "reset_read");
    endtask

    task automatic test_insert();
        logic [7:0] vals[3] = '{8'h50, 8'h10, 8'h30};
        for (int i = 0; i < 3; i++) begin
            spi_insert(8, {8'h00, vals[i]});
            n_checks++;
            if (count8 !== 2'(i + 1)) begin
                n_fail++;
                $display("FAIL insert_count%0d: got %0d want %0d", i, count8, i + 1);
            end
        end
        n_checks++;
        if (full8 !== 1'b1) begin
            n_fail++;
            $display("FAIL insert_full: got %0b want 1", full8);
        end
        spi_read(8, "insert_read");
    endtask

    task automatic test_full();
        spi_insert(8, 16'h0020);
        spi_read(8, "full_evict_read");
        spi_insert(8, 16'h0060);
        spi_read(8, "full_ignore_read");
        n_checks++;
        if (count8 !== 2'd3 || full8 !== 1'b1) begin
            n_fail++;
            $display("FAIL full_ignore_count: got count=%0d full=%0b want 3 1", count8, full8);
        end
    endtask

    task automatic test_wide();
        spi_insert(12, 16'hF456);
        n_checks++;
        if (count12 !== 2'd1) begin
            n_fail++;
            $display("FAIL wide_count: got %0d want 1", count12);
        end
        spi_read(12, "wide_read");
        spi_count(12, "wide_count_cmd");
    endtask

    task automatic test_clear();
        spi_clear(8);
        n_checks++;
        if (count8 !== 2'd0 || full8 !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_count: got count=%0d full=%0b want 0 0", count8, full8);
        end
        spi_read(8, "clear_read");
    endtask

    task automatic test_abort();
        logic [7:0] rx;
        frame_begin(8);
        spi_bits(8, 8'h01, 8, rx);
        spi_bits(8, 8'hA0, 4, rx);
        frame_end(8);
        n_checks++;
        if (count8 !== 2'd0) begin
            n_fail++;
            $display("FAIL abort_count: got %0d want 0", count8);
        end
        spi_insert(8, 16'h0007);
        n_checks++;
        if (count8 !== 2'd1) begin
            n_fail++;
            $display("FAIL abort_next_count: got %0d want 1", count8);
        end
    endtask

    task automatic test_bad_cmd();
        logic [7:0] rx;
        logic [7:0] seen;
        seen = '0;
        frame_begin(8);
        spi_bits(8, 8'h7E, 8, rx);
        seen |= rx;
        spi_bits(8, 8'hFF, 8, rx);
        seen |= rx;
        spi_bits(8, 8'h01, 8, rx);
        seen |= rx;
        frame_end(8);
        n_checks++;
        if (seen !== 8'h00) begin
            n_fail++;
            $display("FAIL bad_cmd_miso: got %02h want 00", seen);
        end
        n_checks++;
        if (count8 !== 2'd1) begin
            n_fail++;
            $display("FAIL bad_cmd_count: got %0d want 1", count8);
        end
        spi_read(8, "bad_cmd_read");
    endtask

    task automatic test_reset_mid();
        logic [7:0] rx;
        frame_begin(8);
        spi_bits(8, 8'h01, 8, rx);
        spi_bits(8, 8'h90, 4, rx);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model8.delete();
        model12.delete();
        spi_bits(8, 8'h01, 8, rx);
        spi_bits(8, 8'h44, 8, rx);
        frame_end(8);
        n_checks++;
        if (count8 !== 2'd0 || count12 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_mid_count: got %0d/%0d want 0/0", count8, count12);
        end
        spi_insert(8, 16'h0033);
        n_checks++;
        if (count8 !== 2'd1) begin
            n_fail++;
            $display("FAIL reset_mid_next_count: got %0d want 1", count8);
        end
        spi_read(8, "reset_mid_read");
    endtask

    initial begin
        if8.sck  = 1'b0;  if12.sck  = 1'b0;
        if8.mosi = 1'b0;  if12.mosi = 1'b0;
        if8.cs   = 1'b1;  if12.cs   = 1'b1;
        reset = 1'b1;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        test_reset();
        test_insert();
        test_full();
        test_wide();
        test_clear();
        test_abort();
        test_bad_cmd();
        test_reset_mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
